// File: rtl/seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// seq_gen_pkg
// Shared definitions for the multi-mode sequence generator.
//   MODE_*      : 2-bit mode encodings (binary, Gray, Johnson, one-hot ring)
//   code_t      : widest supported code (16 bits); callers size-cast down
//   width_mask  : all-ones mask of a given width
//   bin2gray    : binary -> Gray conversion
//   gray2bin    : Gray -> binary conversion
//   start_code  : first code of a mode's sequence at width w
//   last_code   : final code of a mode's sequence at width w
// ---------------------------------------------------------------------------
package seq_gen_pkg;

  localparam int MAX_W = 16;

  typedef logic [MAX_W-1:0] code_t;

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;
  localparam logic [1:0] MODE_RING = 2'b11;

  // Shifting a 16-bit one by 16 wraps to zero, so w=16 still yields all-ones.
  function automatic code_t width_mask(input int w);
    return (code_t'(1) << w) - code_t'(1);
  endfunction

  function automatic code_t bin2gray(input code_t b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits of a narrower code are zero, so converting at full width is safe.
  function automatic code_t gray2bin(input code_t g);
    code_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic code_t start_code(input logic [1:0] m, input int w);
    code_t c;
    c = (m == MODE_RING) ? code_t'(1) : '0;
    return c & width_mask(w);
  endfunction

  // Gray's last code is gray(2^w-1), which is the MSB alone.
  function automatic code_t last_code(input logic [1:0] m, input int w);
    if (m == MODE_BIN) begin
      return width_mask(w);
    end
    return code_t'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/seq_gen_next.sv
// ---------------------------------------------------------------------------
// seq_gen_next
// Combinational next-code logic for the sequence generator.
//   seq      (in)  : current code
//   mode     (in)  : code family, see MODE_* in seq_gen_pkg
//   dir      (in)  : 1 = forward, 0 = reverse
//   next     (out) : code after one step (start code if seq is illegal)
//   wrap_hit (out) : this step crosses between last and start code
//   illegal  (out) : seq is not a member of the selected code family
// ---------------------------------------------------------------------------
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] seq,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             wrap_hit,
  output logic             illegal
);

  logic [WIDTH-1:0] startCode;
  logic [WIDTH-1:0] lastCode;
  logic [WIDTH-1:0] grayBin;
  logic [WIDTH-1:0] grayBinNext;
  logic [WIDTH-1:0] invSeq;
  logic             johnLegal;
  logic             ringLegal;

  assign startCode   = WIDTH'(start_code(mode, WIDTH));
  assign lastCode    = WIDTH'(last_code(mode, WIDTH));
  assign grayBin     = WIDTH'(gray2bin(code_t'(seq)));
  assign grayBinNext = dir ? grayBin + WIDTH'(1) : grayBin - WIDTH'(1);
  assign invSeq      = ~seq;

  // A Johnson code is a run of ones anchored at the LSB (0..01..1) or at the
  // MSB (1..10..0); x & (x+1) is zero exactly for the LSB-anchored form.
  assign johnLegal = ((seq & (seq + WIDTH'(1))) == '0) ||
                     ((invSeq & (invSeq + WIDTH'(1))) == '0);

  assign ringLegal = (seq != '0) && ((seq & (seq - WIDTH'(1))) == '0);

  // Compute the step for the selected family, then override with the start
  // code on an illegal input. Wrap is only possible from a legal code.
  always_comb begin
    next     = seq;
    wrap_hit = 1'b0;
    illegal  = 1'b0;
    case (mode)
      MODE_BIN: begin
        next = dir ? seq + WIDTH'(1) : seq - WIDTH'(1);
      end
      MODE_GRAY: begin
        next = WIDTH'(bin2gray(code_t'(grayBinNext)));
      end
      MODE_JOHN: begin
        illegal = !johnLegal;
        next    = dir ? {seq[WIDTH-2:0], ~seq[WIDTH-1]}
                      : {~seq[0], seq[WIDTH-1:1]};
      end
      default: begin
        illegal = !ringLegal;
        next    = dir ? {seq[WIDTH-2:0], seq[WIDTH-1]}
                      : {seq[0], seq[WIDTH-1:1]};
      end
    endcase
    if (illegal) begin
      next = startCode;
    end else begin
      wrap_hit = dir ? (seq == lastCode) : (seq == startCode);
    end
  end

endmodule

// File: rtl/seq_gen_n.sv
// ---------------------------------------------------------------------------
// seq_gen_n
// WIDTH-generic multi-mode sequence generator (binary, Gray, Johnson, ring)
// with up/down direction, seed load, one-shot halt and a wrap strobe.
//   clk     (in)  : clock, all state updates on rising edge
//   rst     (in)  : synchronous active-high reset
//   en      (in)  : advance one step this cycle
//   dir     (in)  : 1 = up, 0 = down
//   mode    (in)  : 00 binary, 01 Gray, 10 Johnson, 11 ring
//   ld      (in)  : load seed into seq
//   seed    (in)  : value loaded when ld=1
//   oneshot (in)  : halt after the first wrap
//   seq     (out) : current code, registered
//   wrap    (out) : registered one-cycle strobe after a wrap step
//   done    (out) : one-shot halted flag
// ---------------------------------------------------------------------------
module seq_gen_n
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] seed,
  input  logic             oneshot,
  output logic [WIDTH-1:0] seq,
  output logic             wrap,
  output logic             done
);

  logic [1:0]       mode_q;
  logic [WIDTH-1:0] nextCode;
  logic [WIDTH-1:0] startCode;
  logic             wrapHit;
  logic             illegal;
  logic             modeChange;

  assign modeChange = (mode != mode_q);
  assign startCode  = WIDTH'(start_code(mode, WIDTH));

  seq_gen_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .seq     (seq),
    .mode    (mode),
    .dir     (dir),
    .next    (nextCode),
    .wrap_hit(wrapHit),
    .illegal (illegal)
  );

  // Prioritised update: reset, load, mode change, step, hold. mode_q tracks
  // the mode input every cycle so a change is seen for exactly one edge.
  // In the hold branch, done survives only while oneshot stays asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq    <= '0;
      wrap   <= 1'b0;
      done   <= 1'b0;
      mode_q <= MODE_BIN;
    end else begin
      mode_q <= mode;
      if (ld) begin
        seq  <= seed;
        wrap <= 1'b0;
        done <= 1'b0;
      end else if (modeChange) begin
        seq  <= startCode;
        wrap <= 1'b0;
        done <= 1'b0;
      end else if (en && !done) begin
        seq  <= nextCode;
        wrap <= wrapHit && !illegal;
        done <= oneshot && wrapHit && !illegal;
      end else begin
        wrap <= 1'b0;
        done <= done && oneshot;
      end
    end
  end

endmodule
